// File: rtl/lanczos_table_loader_if.sv
// Handshake and readout bundle for the Lanczos coefficient table loader.
// The slave side is the loader; the master side feeds words and reads coefficients.
interface lanczos_table_loader_if #(
  parameter int STEP      = 4096,
  parameter int COE_WIDTH = 10
);
  localparam int N    = STEP / 4;
  localparam int DX_W = (N > 1) ? $clog2(N) : 1;

  logic                 load_start;
  logic [COE_WIDTH-1:0] load_data;
  logic                 load_valid;
  logic                 load_ready;
  logic                 load_done;
  logic                 swap;
  logic                 active_bank;
  logic                 table_valid;
  logic [DX_W-1:0]      dx;
  logic [COE_WIDTH-1:0] coe0;
  logic [COE_WIDTH-1:0] coe1;
  logic [COE_WIDTH-1:0] coe2;
  logic [COE_WIDTH-1:0] coe3;
  logic [COE_WIDTH-1:0] coe4;
  logic [COE_WIDTH-1:0] coe5;

  modport slave (
    input  load_start, load_data, load_valid, swap, dx,
    output load_ready, load_done, active_bank, table_valid,
           coe0, coe1, coe2, coe3, coe4, coe5
  );

  modport master (
    output load_start, load_data, load_valid, swap, dx,
    input  load_ready, load_done, active_bank, table_valid,
           coe0, coe1, coe2, coe3, coe4, coe5
  );
endinterface

// File: rtl/lanczos_table_loader.sv
// Double-buffered Lanczos coefficient store: six N-entry tables per bank.
// The shadow bank is filled word by word in table-major order, then a swap
// makes it the active bank that feeds the six registered tap outputs.
// STEP and COE_WIDTH must match the parameters of the connected interface.
module lanczos_table_loader #(
  parameter int STEP      = 4096,
  parameter int COE_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  lanczos_table_loader_if.slave bus
);
  localparam int N    = STEP / 4;
  localparam int DX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DX_W-1:0] ADDR_LAST = DX_W'(N - 1);
  localparam logic [2:0]      TBL_LAST  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t          r_state, w_state_next;
  logic [DX_W-1:0] r_addr, w_addr_next;
  logic [2:0]      r_tbl, w_tbl_next;
  logic            r_load_done, w_done_next;
  logic            r_shadow_full, w_full_next;
  logic            r_active_bank, w_bank_next;
  logic            r_table_valid, w_valid_next;
  logic            w_we;

  // State, counters and bank bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_tbl         <= '0;
      r_load_done   <= 1'b0;
      r_shadow_full <= 1'b0;
      r_active_bank <= 1'b0;
      r_table_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_addr        <= w_addr_next;
      r_tbl         <= w_tbl_next;
      r_load_done   <= w_done_next;
      r_shadow_full <= w_full_next;
      r_active_bank <= w_bank_next;
      r_table_valid <= w_valid_next;
    end
  end

  // Next-state logic; load_start always wins over a same-cycle word or swap
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_tbl_next   = r_tbl;
    w_done_next  = 1'b0;
    w_full_next  = r_shadow_full;
    w_bank_next  = r_active_bank;
    w_valid_next = r_table_valid;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE, S_READY: begin
        if (bus.load_start) begin
          w_state_next = S_LOAD;
          w_addr_next  = '0;
          w_tbl_next   = '0;
          w_full_next  = 1'b0;
        end else if (r_state == S_READY && bus.swap && r_shadow_full) begin
          w_state_next = S_IDLE;
          w_bank_next  = ~r_active_bank;
          w_valid_next = 1'b1;
          w_full_next  = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.load_start) begin
          w_addr_next = '0;
          w_tbl_next  = '0;
          w_full_next = 1'b0;
        end else if (bus.load_valid) begin
          w_we = 1'b1;
          if (r_addr == ADDR_LAST) begin
            w_addr_next = '0;
            if (r_tbl == TBL_LAST) begin
              w_state_next = S_READY;
              w_tbl_next   = '0;
              w_done_next  = 1'b1;
              w_full_next  = 1'b1;
            end else begin
              w_tbl_next = r_tbl + 3'd1;
            end
          end else begin
            w_addr_next = r_addr + DX_W'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.load_ready  = (r_state == S_LOAD);
  assign bus.load_done   = r_load_done;
  assign bus.active_bank = r_active_bank;
  assign bus.table_valid = r_table_valid;

  // One RAM per tap; the bank bit is the address MSB so both banks share it
  for (genvar gi = 0; gi < 6; gi++) begin : g_tab
    logic [COE_WIDTH-1:0] r_mem [0:2*N-1];
    logic [COE_WIDTH-1:0] r_coe;

    // Shadow-bank write of the word belonging to this table
    always_ff @(posedge clk) begin
      if (w_we && r_tbl == 3'(gi))
        r_mem[{~r_active_bank, r_addr}] <= bus.load_data;
    end

    // Registered readout; all taps use the same bank bit so samples never mix
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_coe <= '0;
      else if (r_table_valid)
        r_coe <= r_mem[{r_active_bank, bus.dx}];
      else
        r_coe <= '0;
    end
  end

  assign bus.coe0 = g_tab[0].r_coe;
  assign bus.coe1 = g_tab[1].r_coe;
  assign bus.coe2 = g_tab[2].r_coe;
  assign bus.coe3 = g_tab[3].r_coe;
  assign bus.coe4 = g_tab[4].r_coe;
  assign bus.coe5 = g_tab[5].r_coe;
endmodule

// File: doc/lanczos_table_loader.md
LANCZOS_TABLE_LOADER -- requirements
Module: lanczos_table_loader

Interface
REQ-001 SHALL have parameter STEP, default 4096, meaning interpolation phase resolution; each coefficient table holds N = STEP/4 entries.
REQ-002 SHALL have parameter COE_WIDTH, default 10, meaning bit width of one coefficient.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse that begins loading the shadow bank.
REQ-006 SHALL have port load_data  input  COE_WIDTH  coefficient word.
REQ-007 SHALL have port load_valid  input  1  load_data is valid.
REQ-008 SHALL have port load_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port load_done  output  1  one-cycle pulse after the last of 6*N words is accepted.
REQ-010 SHALL have port swap  input  1  one-cycle request to make the shadow bank active.
REQ-011 SHALL have port active_bank  output  1  index of the bank currently driving coe0..coe5.
REQ-012 SHALL have port table_valid  output  1  an active bank holds a completely loaded table set.
REQ-013 SHALL have port dx  input  log2(N)  phase index for readout.
REQ-014 SHALL have ports coe0..coe5  output  COE_WIDTH each  registered coefficients for taps 0..5.

Function
REQ-015 SHALL store two banks, each of six N-entry tables; the active bank is readout-only and the other bank (shadow) is write-only.
REQ-016 SHALL implement an FSM with states IDLE, LOAD, and READY (shadow fully loaded and awaiting swap).
REQ-017 SHALL transition IDLE->LOAD and READY->LOAD on load_start; address and table counters clear to 0 and shadow_full clears.
REQ-018 SHALL drive load_ready = 1 only in LOAD; a word is accepted on cycles where load_valid and load_ready are both 1.
REQ-019 SHALL write word k (0 <= k < 6*N) to shadow table floor(k/N), entry k mod N, in table-major order; the address wraps N-1->0 and the table index increments.
REQ-020 SHALL, on acceptance of word 6*N-1, go to READY, pulse load_done the next cycle, and set shadow_full.
REQ-021 SHALL restart the load from word 0 when load_start arrives in LOAD; that load_start takes priority over a word accepted in the same cycle, which is discarded.
REQ-022 SHALL, when swap=1 in READY, toggle active_bank, set table_valid=1, clear shadow_full, and go to IDLE, all on the same clock edge.
REQ-023 SHALL ignore swap in IDLE and LOAD, leaving active_bank and table_valid unchanged.
REQ-024 SHALL give load_start priority when load_start and swap arrive together in READY: no swap, enter LOAD.
REQ-025 SHALL register coe0..coe5 every cycle from active-bank tables 0..5 at index dx, with a latency of 1 cycle.
REQ-026 SHALL present coe outputs from the new bank starting with the sample registered on the edge after active_bank toggles; samples SHALL never mix taps from two banks.
REQ-027 SHALL hold coe0..coe5 at 0 while table_valid = 0.
REQ-028 SHALL perform no arithmetic on coefficients; words are stored bit-exact.

Reset
REQ-029 SHALL, while rst = 1, force state IDLE, load_ready 0, load_done 0, active_bank 0, table_valid 0, shadow_full 0, counters 0, and coe0..coe5 0.
REQ-030 SHALL define table RAM contents after reset as don't-care; they become defined only through a load followed by a swap.
REQ-031 SHALL, when reset is asserted mid-LOAD, abandon the partial load; a fresh load_start is required afterwards.

Verification (STEP=16, N=4, dx 2 bits, COE_WIDTH=10)
REQ-032 SHALL cover: reset release, dx swept 0..3 -> coe0..5 = 0, table_valid=0, active_bank=0.
REQ-033 SHALL cover: load_start, 24 words value = 16*t+e (t = table, e = entry) with load_valid held 1, then swap -> load_done pulses once, active_bank=1, dx=2 gives coe3=50 one cycle later.
REQ-034 SHALL cover: random load_valid gaps during a load -> identical contents to REQ-033, load_done only after the 24th accepted word.
REQ-035 SHALL cover: load_start after word 10, then reload of 24 words with value 0x3FF-k -> after swap coe0 at dx=0 = 0x3FF, and no data from the first attempt survives.
REQ-036 SHALL cover: swap during LOAD, and swap with load_start in the same cycle in READY -> active_bank unchanged, and the FSM is in LOAD in the second case.
REQ-037 SHALL cover: rst asserted mid-LOAD at word 7 -> load_ready=0 immediately, all outputs reset, and a subsequent swap is ignored.
